// File: rtl/fht_out_mix_if.sv
`default_nettype none
// ============================================================================
// Module   : fht_out_mix_if
// Brief    : Beat bus from the butterfly into the write-back router, and the
//            per-bank write port from the router to the four RAM banks.
// Revision : 1.0
// ============================================================================
interface fht_out_mix_if #(
    parameter int D_BIT = 17,
    parameter int A_BIT = 8
);
    logic                    iVALID;
    logic [A_BIT-1:0]        iSECTOR;
    logic [A_BIT-1:0]        iADDR;
    logic signed [D_BIT:0]   iRES_A;
    logic signed [D_BIT:0]   iRES_B;

    logic [3:0]              oWE;
    logic [A_BIT-1:0]        oADDR;
    logic signed [D_BIT-1:0] oDATA_0;
    logic signed [D_BIT-1:0] oDATA_1;
    logic signed [D_BIT-1:0] oDATA_2;
    logic signed [D_BIT-1:0] oDATA_3;

    modport master (
        output iVALID, iSECTOR, iADDR, iRES_A, iRES_B,
        input  oWE, oADDR, oDATA_0, oDATA_1, oDATA_2, oDATA_3
    );

    modport slave (
        input  iVALID, iSECTOR, iADDR, iRES_A, iRES_B,
        output oWE, oADDR, oDATA_0, oDATA_1, oDATA_2, oDATA_3
    );
endinterface
`default_nettype wire

// File: rtl/fht_out_mix.sv
`default_nettype none
// ============================================================================
// Module   : fht_out_mix
// Brief    : FHT write-back router: narrows and steers butterfly results to the
//            idle bank half, counts beats per stage. Optional saturation with
//            sticky overflow under macro FHT_OUT_SAT_EN.
// Revision : 1.0
// ============================================================================
module fht_out_mix #(
    parameter int D_BIT = 17,
    parameter int A_BIT = 8
) (
    input  logic          iCLK,
    input  logic          iRESET,
    input  logic          iSTAGE_START,
    input  logic          iSTAGE_ODD,
    input  logic          iST_ZERO,
    fht_out_mix_if.slave  bus,
    output logic          oBUSY,
    output logic          oSTAGE_DONE,
    output logic          oOVF
);

    localparam logic [A_BIT:0]         c_BEATS = {1'b1, {A_BIT{1'b0}}};
    localparam logic signed [D_BIT-1:0] c_MAX  = {1'b0, {(D_BIT-1){1'b1}}};
    localparam logic signed [D_BIT-1:0] c_MIN  = {1'b1, {(D_BIT-1){1'b0}}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } t_state;

    function automatic logic signed [D_BIT-1:0] f_narrow(input logic signed [D_BIT:0] v);
`ifdef FHT_OUT_SAT_EN
        if (v[D_BIT] != v[D_BIT-1])
            f_narrow = v[D_BIT] ? c_MIN : c_MAX;
        else
            f_narrow = v[D_BIT-1:0];
`else
        f_narrow = v[D_BIT-1:0];
`endif
    endfunction

    // ---------------- routing ----------------
    logic signed [D_BIT-1:0] w_nar_a, w_nar_b, w_lo, w_hi;
    logic signed [D_BIT-1:0] w_d0, w_d1, w_d2, w_d3;
    logic [3:0]              w_we;
    logic                    w_swap;

    always_comb begin
        w_nar_a = f_narrow(bus.iRES_A);
        w_nar_b = f_narrow(bus.iRES_B);
        // Odd sectors had their operands swapped on the read side; swap back.
        w_swap  = ~iST_ZERO & bus.iSECTOR[0];
        w_lo    = w_swap ? w_nar_b : w_nar_a;
        w_hi    = w_swap ? w_nar_a : w_nar_b;
        w_we    = 4'b0000;
        w_d0    = '0;
        w_d1    = '0;
        w_d2    = '0;
        w_d3    = '0;
        if (bus.iVALID) begin
            if (iSTAGE_ODD) begin
                w_we = 4'b0011;
                w_d0 = w_lo;
                w_d1 = w_hi;
            end else begin
                w_we = 4'b1100;
                w_d2 = w_lo;
                w_d3 = w_hi;
            end
        end
    end

    logic [3:0]              r_we;
    logic [A_BIT-1:0]        r_addr;
    logic signed [D_BIT-1:0] r_d0, r_d1, r_d2, r_d3;

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_we   <= 4'b0000;
            r_addr <= '0;
            r_d0   <= '0;
            r_d1   <= '0;
            r_d2   <= '0;
            r_d3   <= '0;
        end else begin
            r_we <= w_we;
            r_d0 <= w_d0;
            r_d1 <= w_d1;
            r_d2 <= w_d2;
            r_d3 <= w_d3;
            if (bus.iVALID)
                r_addr <= bus.iADDR;
        end
    end

    assign bus.oWE     = r_we;
    assign bus.oADDR   = r_addr;
    assign bus.oDATA_0 = r_d0;
    assign bus.oDATA_1 = r_d1;
    assign bus.oDATA_2 = r_d2;
    assign bus.oDATA_3 = r_d3;

    // ---------------- stage beat counter ----------------
    t_state         r_state, w_state_nx;
    logic [A_BIT:0] r_cnt, w_cnt_nx, w_cnt_inc;
    logic           r_done, w_done_nx;

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_done  <= w_done_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_done_nx  = 1'b0;
        w_cnt_inc  = r_cnt + 1'b1;
        if (iSTAGE_START) begin
            // A restart drops the running count without signalling completion.
            w_state_nx = ST_BUSY;
            w_cnt_nx   = {{A_BIT{1'b0}}, bus.iVALID};
        end else if (r_state == ST_BUSY && bus.iVALID) begin
            if (w_cnt_inc == c_BEATS) begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = '0;
                w_done_nx  = 1'b1;
            end else begin
                w_cnt_nx   = w_cnt_inc;
            end
        end
    end

    assign oBUSY       = (r_state == ST_BUSY);
    assign oSTAGE_DONE = r_done;

    logic w_unused_sector;
    assign w_unused_sector = ^bus.iSECTOR[A_BIT-1:1];

    // ---------------- overflow flag ----------------
`ifdef FHT_OUT_SAT_EN
    logic w_clip;
    logic r_ovf;

    assign w_clip = bus.iVALID &
                    ((bus.iRES_A[D_BIT] ^ bus.iRES_A[D_BIT-1]) |
                     (bus.iRES_B[D_BIT] ^ bus.iRES_B[D_BIT-1]));

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET)
            r_ovf <= 1'b0;
        else
            r_ovf <= (r_ovf & ~(iSTAGE_START & iST_ZERO)) | w_clip;
    end

    assign oOVF = r_ovf;
`else
    logic w_unused_msb;
    assign w_unused_msb = bus.iRES_A[D_BIT] ^ bus.iRES_B[D_BIT];
    assign oOVF         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fht_out_mix.sv
`default_nettype none
// ============================================================================
// Module   : tb_fht_out_mix
// Brief    : Directed self-checking bench for fht_out_mix with a scoreboard of
//            expected writes; follows FHT_OUT_SAT_EN if defined.
// Revision : 1.0
// ============================================================================
module tb_fht_out_mix;
    localparam int D_BIT = 17;
    localparam int A_BIT = 4;
    localparam int BEATS = 16;
    localparam int MAXV  = 65535;
    localparam int MINV  = -65536;

    logic iCLK = 1'b0;
    logic iRESET = 1'b0;
    logic start = 1'b0;
    logic odd = 1'b0;
    logic stz = 1'b0;
    logic busy, done, ovf;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;

    fht_out_mix_if #(.D_BIT(D_BIT), .A_BIT(A_BIT)) bus ();

    fht_out_mix #(.D_BIT(D_BIT), .A_BIT(A_BIT)) dut (
        .iCLK         (iCLK),
        .iRESET       (iRESET),
        .iSTAGE_START (start),
        .iSTAGE_ODD   (odd),
        .iST_ZERO     (stz),
        .bus          (bus),
        .oBUSY        (busy),
        .oSTAGE_DONE  (done),
        .oOVF         (ovf)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic [3:0]       we;
        logic [A_BIT-1:0] addr;
        logic [D_BIT-1:0] d0, d1, d2, d3;
        logic             busy, done, ovf;
    } req_t;

    req_t sb[$];

    logic [A_BIT-1:0] m_addr = '0;
    int               m_cnt  = 0;
    logic             m_busy = 1'b0;
    logic             m_ovf  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        assert (obs === req) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, req);
        end
    endtask

    function automatic logic [D_BIT-1:0] narrow(input int v);
        logic [31:0] t;
`ifdef FHT_OUT_SAT_EN
        if (v > MAXV) v = MAXV;
        if (v < MINV) v = MINV;
`endif
        t = v;
        return t[D_BIT-1:0];
    endfunction

    function automatic logic clips(input int v);
        return (v > MAXV) || (v < MINV);
    endfunction

    task automatic beat(input logic s, input logic o, input logic z, input int sec,
                        input logic v, input int addr, input int a, input int b);
        req_t  e, g;
        logic  swap;
        logic [D_BIT-1:0] lo, hi;
        start = s; odd = o; stz = z; bus.iVALID = v;
        bus.iSECTOR = sec[A_BIT-1:0];
        bus.iADDR   = addr[A_BIT-1:0];
        bus.iRES_A  = a[D_BIT:0];
        bus.iRES_B  = b[D_BIT:0];
        e.we = 4'b0000; e.d0 = '0; e.d1 = '0; e.d2 = '0; e.d3 = '0; e.done = 1'b0;
        if (v) begin
            swap = !z && (sec % 2 == 1);
            lo = narrow(swap ? b : a);
            hi = narrow(swap ? a : b);
            if (o) begin e.we = 4'b0011; e.d0 = lo; e.d1 = hi; end
            else   begin e.we = 4'b1100; e.d2 = lo; e.d3 = hi; end
            m_addr = addr[A_BIT-1:0];
        end
        e.addr = m_addr;
        if (s) begin
            m_busy = 1'b1;
            m_cnt  = v ? 1 : 0;
        end else if (m_busy && v) begin
            m_cnt++;
            if (m_cnt == BEATS) begin e.done = 1'b1; m_busy = 1'b0; m_cnt = 0; end
        end
        e.busy = m_busy;
`ifdef FHT_OUT_SAT_EN
        if (s && z) m_ovf = 1'b0;
        if (v && (clips(a) || clips(b))) m_ovf = 1'b1;
`endif
        e.ovf = m_ovf;
        sb.push_back(e);
        @(posedge iCLK); #1;
        start = 1'b0; bus.iVALID = 1'b0;
        g = sb.pop_front();
        if (done === 1'b1) n_done++;
        chk("we",   {28'd0, bus.oWE},   {28'd0, g.we});
        chk("addr", {28'd0, bus.oADDR}, {28'd0, g.addr});
        chk("d0",   {15'd0, bus.oDATA_0}, {15'd0, g.d0});
        chk("d1",   {15'd0, bus.oDATA_1}, {15'd0, g.d1});
        chk("d2",   {15'd0, bus.oDATA_2}, {15'd0, g.d2});
        chk("d3",   {15'd0, bus.oDATA_3}, {15'd0, g.d3});
        chk("busy", {31'd0, busy}, {31'd0, g.busy});
        chk("done", {31'd0, done}, {31'd0, g.done});
        chk("ovf",  {31'd0, ovf},  {31'd0, g.ovf});
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_we"},   {28'd0, bus.oWE},   32'd0);
        chk({tag, "_addr"}, {28'd0, bus.oADDR}, 32'd0);
        chk({tag, "_data"}, {15'd0, bus.oDATA_0 | bus.oDATA_1 | bus.oDATA_2 | bus.oDATA_3}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_ovf"},  {31'd0, ovf},  32'd0);
    endtask

    task automatic model_reset();
        m_addr = '0; m_cnt = 0; m_busy = 1'b0; m_ovf = 1'b0;
        sb.delete();
    endtask

    initial begin
        bus.iVALID = 1'b0; bus.iSECTOR = '0; bus.iADDR = '0;
        bus.iRES_A = '0; bus.iRES_B = '0;

        // Reset state
        repeat (2) @(posedge iCLK);
        #1 rst_chk("reset");
        #3 iRESET = 1'b1;
        model_reset();
        beat(0, 0, 0, 0, 0, 0, 0, 0);

        // Zero stage: no swap even for odd sector; not counted while idle
        beat(0, 0, 1, 3, 1, 9, 100, -7);
        chk("z_we", {28'd0, bus.oWE}, 32'h0000000C);
        chk("z_d2", {15'd0, bus.oDATA_2}, 32'd100);
        chk("z_d3", {15'd0, bus.oDATA_3}, 32'h0001FFF9);
        chk("z_busy", {31'd0, busy}, 32'd0);

        // Odd stage, sector swap
        beat(0, 1, 0, 1, 1, 4, 5, 6);
        chk("s1_d1", {15'd0, bus.oDATA_1}, 32'd5);
        chk("s1_d0", {15'd0, bus.oDATA_0}, 32'd6);
        beat(0, 1, 0, 2, 1, 5, 5, 6);
        chk("s2_d0", {15'd0, bus.oDATA_0}, 32'd5);
        chk("s2_d1", {15'd0, bus.oDATA_1}, 32'd6);
        beat(0, 0, 0, 5, 1, 6, -40000, 123);

        // Narrowing of +70000 and -70000
        beat(0, 0, 0, 0, 1, 7, 70000, -70000);
`ifdef FHT_OUT_SAT_EN
        chk("nar_d2", {15'd0, bus.oDATA_2}, 32'd65535);
        chk("nar_ovf", {31'd0, ovf}, 32'd1);
`else
        chk("nar_d2", {15'd0, bus.oDATA_2}, 32'd70000);
        chk("nar_ovf", {31'd0, ovf}, 32'd0);
`endif

        // Full stage with a gap; overflow stays through a non-zero stage start
        n_done = 0;
        beat(1, 1, 0, 0, 1, 0, 1, 2);
        beat(0, 1, 0, 1, 1, 1, 3, 4);
        beat(0, 1, 0, 0, 0, 15, 9, 9);
        chk("gap_we", {28'd0, bus.oWE}, 32'd0);
        chk("gap_addr", {28'd0, bus.oADDR}, 32'd1);
        for (int i = 2; i < BEATS - 1; i++)
            beat(0, 1, 0, i, 1, i, i * 1000, -i * 1000);
        chk("pre_done", {31'd0, done}, 32'd0);
        chk("pre_busy", {31'd0, busy}, 32'd1);
        beat(0, 1, 0, 15, 1, 15, 7, 8);
        chk("st_done", {31'd0, done}, 32'd1);
        chk("st_busy", {31'd0, busy}, 32'd0);
        beat(0, 1, 0, 0, 0, 0, 0, 0);
        chk("done_cnt", n_done, 32'd1);

        // Zero-stage start clears overflow
        beat(1, 0, 1, 0, 0, 0, 0, 0);
        chk("ovf_clr", {31'd0, ovf}, 32'd0);

        // Restart mid-stage: no completion for the aborted stage
        n_done = 0;
        beat(0, 0, 1, 0, 1, 1, 10, 20);
        beat(0, 0, 1, 0, 1, 2, 10, 20);
        beat(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < BEATS; i++)
            beat(0, 0, 0, i, 1, i, -i, i);
        chk("rs_done_cnt", n_done, 32'd1);

        // Asynchronous reset mid-stage after 5 beats
        beat(1, 1, 0, 0, 1, 3, 50, -50);
        for (int i = 0; i < 4; i++)
            beat(0, 1, 0, i, 1, i, 70000, 11);
        iRESET = 1'b0;
        #2 rst_chk("mid_rst");
        @(posedge iCLK); #3;
        iRESET = 1'b1;
        model_reset();
        beat(0, 1, 0, 0, 0, 0, 0, 0);
        n_done = 0;
        beat(1, 0, 0, 0, 1, 0, 1, 1);
        for (int i = 1; i < BEATS; i++)
            beat(0, 0, 0, i, 1, i, i, -i);
        chk("post_rst_done", n_done, 32'd1);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
